pll_reconfig_ctrl: RTL
======================

Name: pll_reconfig_ctrl

Overview:
- Sequences one Gowin rPLL in dynamic-divider mode (DYN_IDIV/FBDIV/ODIV_SEL = "true").
- Drives the PLL reset and the IDSEL/FBDSEL/ODSEL buses, and waits for a stable lock with timeout and bounded retry.
- Holds a downstream synchronous reset asserted until the PLL clock is usable.
- Accepts runtime divider changes via a valid/ready handshake. Runs on the PLL reference clock, not the PLL output.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per attempt (≥1).
- LOCK_TIMEOUT, 24000: cycles allowed from pll_reset release to first synchronized lock (1 ms at 24 MHz).
- STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before declaring lock.
- MAX_RETRIES, 3: attempts per configuration before FAIL (≥1).
- IDSEL_INIT, 6'd1: IDSEL value loaded at reset.
- FBDSEL_INIT, 6'd8: FBDSEL value loaded at reset.
- ODSEL_INIT, 6'd8: ODSEL value loaded at reset.

Ports:
- clkin  in  1  reference clock (24 MHz crystal)
- reset  in  1  synchronous active-high reset
- cfg_valid  in  1  new divider set offered
- cfg_ready  out  1  controller can accept a divider set
- cfg_idsel  in  6  requested IDSEL (raw PLL encoding, passed through)
- cfg_fbdsel  in  6  requested FBDSEL
- cfg_odsel  in  6  requested ODSEL
- pll_lock  in  1  rPLL LOCK (asynchronous to clkin)
- pll_reset  out  1  to rPLL RESET
- pll_idsel  out  6  to rPLL IDSEL
- pll_fbdsel  out  6  to rPLL FBDSEL
- pll_odsel  out  6  to rPLL ODSEL
- sys_rst  out  1  downstream reset, high until locked
- locked  out  1  PLL declared stable
- error  out  1  retries exhausted
- retry_cnt  out  2  attempts consumed for current config

Behaviour:
- pll_lock passes through a 2-FF synchronizer (lock_s); 2-cycle latency. All decisions use lock_s.
- Reset values: pll_reset=1, pll_*sel=*_INIT, sys_rst=1, locked=0, error=0, cfg_ready=0, retry_cnt=0, state=RESET_HOLD, counters=0.
- All outputs are registered.
- RESET_HOLD: pll_reset=1, sys_rst=1, locked=0.
  - After exactly RST_CYCLES cycles in this state → WAIT_LOCK; pll_reset=0 from the first WAIT_LOCK cycle.
- WAIT_LOCK: timeout counter increments each cycle.
  - lock_s=1 → STABLE, stable counter cleared.
  - Counter reaches LOCK_TIMEOUT with lock_s=0 → retry_cnt+1.
  - If new retry_cnt < MAX_RETRIES → RESET_HOLD, else → FAIL.
- STABLE: stable counter increments while lock_s=1.
  - lock_s=0 → WAIT_LOCK; timeout counter continues, not reset (glitching lock cannot extend the timeout).
  - STABLE_CYCLES consecutive highs → RUN.
- RUN: sys_rst=0, locked=1, retry_cnt=0, cfg_ready=1.
  - Both deassert on the first RUN cycle.
- FAIL: pll_reset=1, sys_rst=1, error=1, cfg_ready=1.
  - Only a cfg handshake or reset leaves FAIL.
- Handshake: a transfer occurs when cfg_valid & cfg_ready in RUN or FAIL.
  - Next cycle: pll_*sel = cfg_*, sys_rst=1, locked=0, error=0, retry_cnt=0, cfg_ready=0, state=RESET_HOLD.
  - cfg_ready=0 in all other states; cfg_valid is ignored there.
  - Dividers change only while pll_reset=1 or on the same edge pll_reset rises.
- Simultaneous cfg transfer and lock loss in RUN: the cfg transfer wins (new dividers loaded).
- Reset asserted mid-sequence: immediate return to reset values; pll_*sel revert to *_INIT.
- Counters are sized by $clog2 of their parameter and saturate; no wrap.

Optional Feature:
- Macro: PLL_LOCK_MON_EN.
- Defined: in RUN, lock_s=0 for one cycle → next cycle sys_rst=1, locked=0, retry_cnt=0, state=RESET_HOLD, current dividers kept (auto-relock).
- Not defined: lock_s is ignored once in RUN; the controller only leaves RUN on a cfg transfer or reset.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=8, MAX_RETRIES=2):
- Release reset, pll_lock rises 10 cycles after pll_reset falls → pll_reset high exactly 4 cycles; locked=1 and sys_rst=0 exactly 2+8 cycles after pll_lock rises; pll_idsel/fbdsel/odsel=1/8/8.
- pll_lock held low → two 50-cycle timeouts, retry_cnt 1 then 2 → FAIL: error=1, pll_reset=1, sys_rst=1, cfg_ready=1.
- In RUN, cfg_valid with idsel=3, fbdsel=20, odsel=4 → next cycle sys_rst=1, locked=0, pll_reset=1, outputs 3/20/4; relock reaches RUN again.
- pll_lock toggles high 5 cycles / low 1 repeatedly → never reaches RUN; timeout and retry still occur on schedule (no timeout extension).
- With PLL_LOCK_MON_EN: drop pll_lock 1 cycle in RUN → sys_rst=1 within 3 cycles, 4-cycle pll_reset pulse, dividers unchanged. Without it: locked stays 1.
- Assert reset during STABLE after a cfg change → outputs return to 1/8/8, pll_reset=1, error=0, retry_cnt=0 on the next edge.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - Gowin rPLL dynamic-divider sequencer with lock qualification and retry
// Optional macro PLL_LOCK_MON_EN: auto-relock when synchronized lock drops while in RUN.
module pll_reconfig_ctrl #(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_TIMEOUT  = 24000,
  parameter int         STABLE_CYCLES = 256,
  parameter int         MAX_RETRIES   = 3,
  parameter logic [5:0] IDSEL_INIT    = 6'd1,
  parameter logic [5:0] FBDSEL_INIT   = 6'd8,
  parameter logic [5:0] ODSEL_INIT    = 6'd8
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       sys_rst,
  output logic       locked,
  output logic       error,
  output logic [1:0] retry_cnt
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'((MAX_RETRIES > 3) ? 3 : MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_lock_meta;
  logic          r_lock_s;
  logic [RW-1:0] r_rst_cnt;
  logic [RW-1:0] w_rst_cnt_nxt;
  logic [TW-1:0] r_to_cnt;
  logic [TW-1:0] w_to_cnt_nxt;
  logic [SW-1:0] r_stb_cnt;
  logic [SW-1:0] w_stb_cnt_nxt;
  logic [1:0]    r_retry;
  logic [1:0]    w_retry_nxt;
  logic [5:0]    r_idsel;
  logic [5:0]    r_fbdsel;
  logic [5:0]    r_odsel;
  logic          r_pll_reset;
  logic          r_sys_rst;
  logic          r_locked;
  logic          r_error;
  logic          r_cfg_ready;
  logic          w_load_cfg;
  logic          w_xfer;
  logic          w_to_exp;
  logic [TW-1:0] w_to_inc;
  logic [1:0]    w_retry_inc;

  assign w_xfer      = cfg_valid & r_cfg_ready;
  assign w_to_exp    = (r_to_cnt == TO_LAST);
  assign w_to_inc    = w_to_exp ? r_to_cnt : r_to_cnt + TW'(1);
  assign w_retry_inc = (r_retry == 2'd3) ? r_retry : r_retry + 2'd1;

  // pll_lock is asynchronous to clkin; only r_lock_s feeds decisions.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_stb_cnt_nxt = r_stb_cnt;
    w_retry_nxt   = r_retry;
    w_load_cfg    = 1'b0;
    case (r_state)
      S_RESET_HOLD: begin
        if (r_rst_cnt == RST_LAST) begin
          w_next_state  = S_WAIT_LOCK;
          w_rst_cnt_nxt = '0;
          w_to_cnt_nxt  = '0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RW'(1);
        end
      end
      S_WAIT_LOCK: begin
        w_to_cnt_nxt = w_to_inc;
        if (r_lock_s) begin
          // The sample that leaves WAIT_LOCK is the first of the consecutive highs.
          w_next_state  = (STABLE_CYCLES == 1) ? S_RUN : S_STABLE;
          w_stb_cnt_nxt = SW'(1);
        end else if (w_to_exp) begin
          w_retry_nxt   = w_retry_inc;
          w_rst_cnt_nxt = '0;
          w_next_state  = (w_retry_inc < RETRY_MAX) ? S_RESET_HOLD : S_FAIL;
        end
      end
      S_STABLE: begin
        // Timeout keeps running here so a glitching lock cannot stretch an attempt.
        w_to_cnt_nxt = w_to_inc;
        if (r_lock_s) begin
          if (r_stb_cnt == STB_LAST) begin
            w_next_state = S_RUN;
          end else begin
            w_stb_cnt_nxt = r_stb_cnt + SW'(1);
          end
        end else if (w_to_exp) begin
          w_retry_nxt   = w_retry_inc;
          w_rst_cnt_nxt = '0;
          w_next_state  = (w_retry_inc < RETRY_MAX) ? S_RESET_HOLD : S_FAIL;
        end else begin
          w_next_state = S_WAIT_LOCK;
        end
      end
      S_RUN: begin
        w_retry_nxt = 2'd0;
`ifdef PLL_LOCK_MON_EN
        if (!r_lock_s) begin
          w_next_state  = S_RESET_HOLD;
          w_rst_cnt_nxt = '0;
        end
`endif
        if (w_xfer) begin
          w_next_state  = S_RESET_HOLD;
          w_rst_cnt_nxt = '0;
          w_load_cfg    = 1'b1;
        end
      end
      S_FAIL: begin
        if (w_xfer) begin
          w_next_state  = S_RESET_HOLD;
          w_rst_cnt_nxt = '0;
          w_retry_nxt   = 2'd0;
          w_load_cfg    = 1'b1;
        end
      end
      default: begin
        w_next_state  = S_RESET_HOLD;
        w_rst_cnt_nxt = '0;
      end
    endcase
    if (w_next_state == S_RUN) begin
      w_retry_nxt = 2'd0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state     <= S_RESET_HOLD;
      r_rst_cnt   <= '0;
      r_to_cnt    <= '0;
      r_stb_cnt   <= '0;
      r_retry     <= 2'd0;
      r_idsel     <= IDSEL_INIT;
      r_fbdsel    <= FBDSEL_INIT;
      r_odsel     <= ODSEL_INIT;
      r_pll_reset <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_rst_cnt   <= w_rst_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_stb_cnt   <= w_stb_cnt_nxt;
      r_retry     <= w_retry_nxt;
      if (w_load_cfg) begin
        r_idsel  <= cfg_idsel;
        r_fbdsel <= cfg_fbdsel;
        r_odsel  <= cfg_odsel;
      end
      r_pll_reset <= (w_next_state == S_RESET_HOLD) || (w_next_state == S_FAIL);
      r_sys_rst   <= (w_next_state != S_RUN);
      r_locked    <= (w_next_state == S_RUN);
      r_error     <= (w_next_state == S_FAIL);
      r_cfg_ready <= (w_next_state == S_RUN) || (w_next_state == S_FAIL);
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign pll_reset  = r_pll_reset;
  assign pll_idsel  = r_idsel;
  assign pll_fbdsel = r_fbdsel;
  assign pll_odsel  = r_odsel;
  assign sys_rst    = r_sys_rst;
  assign locked     = r_locked;
  assign error      = r_error;
  assign retry_cnt  = r_retry;

endmodule
